// File: rtl/axis_to_gpio_fifo_sync.sv
// rtl/axis_to_gpio_fifo_sync.sv - AXI-Stream slave into a FWFT FIFO presented as GPIO read levels
module axis_to_gpio_fifo_sync #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rlast,
    output logic                  rvalid,
    output logic [AW:0]           level,
    output logic                  underflow
);

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic [AW:0]         count;
    logic                ren_q;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop_req;
    logic                pop;

    assign full          = (count == (AW+1)'(DEPTH));
    assign empty         = (count == '0);
    assign s_axis_tready = ~full & ~rst;
    assign push          = s_axis_tvalid & s_axis_tready;
    assign pop_req       = ren & ~ren_q;
    assign pop           = pop_req & ~empty;

    // Head entry is read combinationally; masked to zero so stale memory never shows.
    assign rdata  = empty ? '0 : mem[rptr][DATA_WIDTH-1:0];
    assign rlast  = empty ? 1'b0 : mem[rptr][DATA_WIDTH];
    assign rvalid = ~empty;
    assign level  = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // ren_q resets high so a ren level held through reset release is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            ren_q     <= 1'b1;
            underflow <= 1'b0;
        end else begin
            ren_q <= ren;
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (pop_req && empty) begin
                underflow <= 1'b1;
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_to_gpio_fifo_sync.sv
// tb/tb_axis_to_gpio_fifo_sync.sv - directed and random bench against a queue reference model
module tb_axis_to_gpio_fifo_sync;

    localparam int DW    = 32;
    localparam int DEPTH = 32;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          ren;
    logic [DW-1:0] rdata;
    logic          rlast;
    logic          rvalid;
    logic [5:0]    level;
    logic          underflow;

    axis_to_gpio_fifo_sync #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .ren           (ren),
        .rdata         (rdata),
        .rlast         (rlast),
        .rvalid        (rvalid),
        .level         (level),
        .underflow     (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW:0] q[$];
    bit          m_ren_q;
    bit          m_uf;
    int          n_cmp;
    int          n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [DW:0] head;
        head = (q.size() != 0) ? q[0] : '0;
        check("tready",    64'(s_axis_tready), 64'(q.size() < DEPTH));
        check("rvalid",    64'(rvalid),        64'(q.size() != 0));
        check("rdata",     64'(rdata),         64'(head[DW-1:0]));
        check("rlast",     64'(rlast),         64'(head[DW]));
        check("level",     64'(level),         64'(q.size()));
        check("underflow", 64'(underflow),     64'(m_uf));
    endtask

    // Advance one clock, then update the model from the inputs seen at that edge.
    task automatic tick();
        bit do_push;
        bit pop_req;
        do_push = s_axis_tvalid && (q.size() < DEPTH);
        pop_req = ren && !m_ren_q;
        @(posedge clk);
        #1;
        if (pop_req) begin
            if (q.size() == 0) m_uf = 1'b1;
            else void'(q.pop_front());
        end
        if (do_push) q.push_back({s_axis_tlast, s_axis_tdata});
        m_ren_q = ren;
        check_outputs();
    endtask

    task automatic model_reset();
        q.delete();
        m_ren_q = 1'b1;
        m_uf    = 1'b0;
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input logic l);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic pop_once();
        ren = 1'b0;
        tick();
        ren = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h1234_5678;
        s_axis_tlast  = 1'b0;
        ren = 1'b1;
        model_reset();

        // T1: reset held with tvalid and ren high
        repeat (3) @(posedge clk);
        #1;
        check("t1_tready", 64'(s_axis_tready), 64'd0);
        check("t1_rvalid", 64'(rvalid), 64'd0);
        check("t1_level",  64'(level), 64'd0);
        s_axis_tvalid = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        check("t1_no_underflow", 64'(underflow), 64'd0);

        // T2: single beat
        push_beat(32'hDEAD_BEEF, 1'b1);
        check("t2_rdata", 64'(rdata), 64'hDEAD_BEEF);
        check("t2_rlast", 64'(rlast), 64'd1);
        check("t2_level", 64'(level), 64'd1);
        pop_once();
        check("t2_empty", 64'(rvalid), 64'd0);

        // T3: fill, blocked beat, partial drain, refill across the wrap
        for (int i = 0; i < DEPTH; i++) push_beat(32'(i), 1'(i % 2));
        check("t3_full_level",  64'(level), 64'd32);
        check("t3_full_tready", 64'(s_axis_tready), 64'd0);
        push_beat(32'd32, 1'b0);
        check("t3_held_level", 64'(level), 64'd32);
        for (int i = 0; i < 5; i++) pop_once();
        check("t3_head5",   64'(rdata), 64'd5);
        check("t3_tready1", 64'(s_axis_tready), 64'd1);
        for (int i = 32; i < 37; i++) push_beat(32'(i), 1'b0);
        for (int k = 5; k < 37; k++) begin
            check("t3_drain", 64'(rdata), 64'(k));
            pop_once();
        end
        check("t3_drained", 64'(level), 64'd0);

        // T4: simultaneous push and pop at level 3
        for (int i = 0; i < 3; i++) push_beat($urandom, 1'b0);
        ren = 1'b0;
        tick();
        ren = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hA5;
        s_axis_tlast  = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        check("t4_level", 64'(level), 64'd3);
        pop_once();
        pop_once();
        check("t4_last_a5", 64'(rdata), 64'hA5);
        pop_once();

        // T5: full with a pop on the same edge as an offered beat
        for (int i = 0; i < DEPTH; i++) push_beat($urandom, 1'($urandom));
        ren = 1'b0;
        tick();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hCAFE;
        ren = 1'b1;
        tick();
        check("t5_no_lookahead", 64'(level), 64'd31);
        tick();
        check("t5_accept_next", 64'(level), 64'd32);
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < DEPTH; i++) pop_once();

        // T6: underflow is sticky until reset
        pop_once();
        check("t6_underflow", 64'(underflow), 64'd1);
        check("t6_level", 64'(level), 64'd0);
        push_beat(32'h77, 1'b0);
        pop_once();
        check("t6_sticky", 64'(underflow), 64'd1);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            s_axis_tvalid = 1'($urandom);
            s_axis_tdata  = $urandom;
            s_axis_tlast  = 1'($urandom);
            ren           = 1'($urandom);
            tick();
        end

        // Mid-transfer asynchronous reset discards the queue
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) push_beat($urandom, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_tready",    64'(s_axis_tready), 64'd0);
        check("async_level",     64'(level), 64'd0);
        check("async_rvalid",    64'(rvalid), 64'd0);
        check("async_underflow", 64'(underflow), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ren = 1'b1;
        tick();
        push_beat(32'h5555_AAAA, 1'b1);
        pop_once();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
